// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: funct3 access codes, FSM states, latched request.
package dmem_responder_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } req_t;

endpackage

// File: rtl/dmem_responder_lane_align.sv
// Byte-lane steering for dmem accesses: byte enables, store shift, load extend, misalign/illegal flags.
// Steering always uses the naturally aligned lane; the caller decides whether misalign traps.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        write_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_sh_o,
  output logic [31:0] rdata_ext_o,
  output logic        misalign_o,
  output logic        illegal_o
);

  logic [1:0]  lo;
  logic [31:0] rsh;

  always_comb begin
    lo         = addr_lo_i;
    be_o       = 4'b0000;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    case (funct3_i)
      F3_LB, F3_LBU: be_o = 4'b0001 << lo;
      F3_LH, F3_LHU: begin
        lo         = {addr_lo_i[1], 1'b0};
        misalign_o = addr_lo_i[0];
        be_o       = 4'b0011 << lo;
      end
      F3_LW: begin
        lo         = 2'b00;
        misalign_o = |addr_lo_i;
        be_o       = 4'b1111;
      end
      default: illegal_o = 1'b1;
    endcase
    // unsigned variants exist only for loads
    if (write_i && funct3_i[2]) illegal_o = 1'b1;
  end

  assign wdata_sh_o = wdata_i << {lo, 3'b000};
  assign rsh        = rword_i >> {lo, 3'b000};

  always_comb begin
    rdata_ext_o = 32'h0;
    case (funct3_i)
      F3_LB:   rdata_ext_o = {{24{rsh[7]}}, rsh[7:0]};
      F3_LBU:  rdata_ext_o = {24'h0, rsh[7:0]};
      F3_LH:   rdata_ext_o = {{16{rsh[15]}}, rsh[15:0]};
      F3_LHU:  rdata_ext_o = {16'h0, rsh[15:0]};
      F3_LW:   rdata_ext_o = rsh;
      default: rdata_ext_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_STATES stall, one-cycle response.
// Define DMEM_MISALIGN_TRAP_EN to report misaligned accesses as errors instead of aligning them.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit MIS_TRAP = 1'b1;
`else
  localparam bit MIS_TRAP = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  req_t            req_q, req_d;
  logic [AW+1:0]   addr_q, addr_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            mem_we;

  logic [3:0][7:0] mem_q [DEPTH_WORDS];
  logic [31:0]     rword;
  logic [3:0]      be;
  logic [31:0]     wdata_sh, rdata_ext;
  logic            misalign, illegal, acc_err;

  // upper address bits are intentionally dropped so accesses wrap
  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];

  assign rword = mem_q[addr_q[AW+1:2]];

  dmem_lane_align u_align (
    .funct3_i    (req_q.funct3),
    .addr_lo_i   (addr_q[1:0]),
    .write_i     (req_q.write),
    .wdata_i     (req_q.wdata),
    .rword_i     (rword),
    .be_o        (be),
    .wdata_sh_o  (wdata_sh),
    .rdata_ext_o (rdata_ext),
    .misalign_o  (misalign),
    .illegal_o   (illegal)
  );

  assign acc_err = illegal | (MIS_TRAP & misalign);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_d   = '{write: req_write, wdata: req_wdata, funct3: req_funct3};
          addr_d  = req_addr[AW+1:0];
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_we  = req_q.write & ~acc_err;
        err_d   = acc_err;
        rdata_d = (req_q.write || acc_err) ? 32'h0 : rdata_ext;
        state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
      addr_q  <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM has no reset; only enabled byte lanes are written
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[addr_q[AW+1:2]][b] <= wdata_sh[b*8 +: 8];
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH_WORDS=64, WAIT_STATES=1).
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One transaction; returns response and cycles from accept to rsp_valid.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] f3, input bit hold,
                      output logic [31:0] rd, output logic er, output int lat);
    bit done;
    @(negedge clk);
    chk("ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_funct3 = f3;
    @(posedge clk); #1;
    if (!hold) begin
      req_valid = 1'b0; req_write = ~w; req_addr = ~a; req_wdata = ~d; req_funct3 = 3'b011;
    end
    lat = 0; done = 1'b0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) done = 1'b1;
      else if (hold) chk("ready_busy", 32'(req_ready), 32'd0);
    end
    rd = rsp_rdata; er = rsp_err;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rsp_one_shot", 32'(rsp_valid), 32'd0);
    chk("rdata_hold", rsp_rdata, rd);
  endtask

  task automatic run(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(w, a, d, f3, 1'b0, rd, er, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd3);
    chk({tag, "_rdata"}, rd, exp_rd);
    chk({tag, "_err"}, 32'(er), 32'(exp_err));
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'd0);

    run("sw10", 1, 32'h10, 32'hDEADBEEF, F3_LW, 32'h0, 0);
    run("lw10", 0, 32'h10, 32'h0, F3_LW, 32'hDEADBEEF, 0);
    run("sh12", 1, 32'h12, 32'hFFFF1234, F3_LH, 32'h0, 0);
    run("lw10b", 0, 32'h10, 32'h0, F3_LW, 32'h1234BEEF, 0);

    run("sw20", 1, 32'h20, 32'h11223344, F3_LW, 32'h0, 0);
    run("lb23", 0, 32'h23, 32'h0, F3_LB, 32'h00000011, 0);
    run("sb21", 1, 32'h21, 32'h00000080, F3_LB, 32'h0, 0);
    run("lb21", 0, 32'h21, 32'h0, F3_LB, 32'hFFFFFF80, 0);
    run("lbu21", 0, 32'h21, 32'h0, F3_LBU, 32'h00000080, 0);
    run("lw20", 0, 32'h20, 32'h0, F3_LW, 32'h11228044, 0);

    run("sw30", 1, 32'h30, 32'h80017FFF, F3_LW, 32'h0, 0);
    run("lh32", 0, 32'h32, 32'h0, F3_LH, 32'hFFFF8001, 0);
    run("lhu32", 0, 32'h32, 32'h0, F3_LHU, 32'h00008001, 0);
    run("lh30", 0, 32'h30, 32'h0, F3_LH, 32'h00007FFF, 0);

    run("sw30b", 1, 32'h30, 32'hCAFEBABE, F3_LW, 32'h0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    run("lw31_mis", 0, 32'h31, 32'h0, F3_LW, 32'h0, 1);
    run("lh33_mis", 0, 32'h33, 32'h0, F3_LH, 32'h0, 1);
    run("sw31_mis", 1, 32'h31, 32'h0, F3_LW, 32'h0, 1);
`else
    run("lw31_mis", 0, 32'h31, 32'h0, F3_LW, 32'hCAFEBABE, 0);
    run("lh33_mis", 0, 32'h33, 32'h0, F3_LH, 32'hFFFFCAFE, 0);
    run("sb31_ok", 1, 32'h31, 32'h000000BA, F3_LB, 32'h0, 0);
`endif
    run("lw30_chk", 0, 32'h30, 32'h0, F3_LW, 32'hCAFEBABE, 0);

    // valid held high across the whole transaction: exactly one accept
    xact(0, 32'h10, 32'h0, F3_LW, 1'b1, rd, er, lat);
    chk("hold_lat", 32'(lat), 32'd3);
    chk("hold_rdata", rd, 32'h1234BEEF);
    repeat (4) begin
      @(negedge clk);
      chk("hold_no_second", 32'(rsp_valid), 32'd0);
    end

    run("f3_011", 0, 32'h10, 32'h0, 3'b011, 32'h0, 1);
    run("f3_111", 0, 32'h10, 32'h0, 3'b111, 32'h0, 1);
    run("st_f3_100", 1, 32'h10, 32'h0, F3_LBU, 32'h0, 1);
    run("lw10_kept", 0, 32'h10, 32'h0, F3_LW, 32'h1234BEEF, 0);

    run("sw_alias", 1, 32'h144, 32'h5A5A0001, F3_LW, 32'h0, 0);
    run("lw_alias", 0, 32'h44, 32'h0, F3_LW, 32'h5A5A0001, 0);

    // reset during WAIT drops the store and its response
    run("sw40", 1, 32'h40, 32'h12345678, F3_LW, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'hAAAAAAAA; req_funct3 = F3_LW;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      chk("rst_drop_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    chk("rst_drop_ready", 32'(req_ready), 32'd1);
    run("lw40_prior", 0, 32'h40, 32'h0, F3_LW, 32'h12345678, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
